// File: rtl/dds_tone_sequencer.sv
// dds_tone_sequencer: table-driven note scheduler feeding the DDS phase increment
module dds_tone_sequencer #(
  parameter int DEPTH    = 16,
  parameter int IDX_W    = 4,
  parameter int DUR_W    = 16,
  parameter int TICK_DIV = 25000
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             WR_EN,
  input  logic [IDX_W-1:0] WR_ADDR,
  input  logic [31:0]      WR_INCR,
  input  logic [DUR_W-1:0] WR_DUR,
  input  logic             START,
  input  logic             STOP,
  input  logic             LOOP,
  input  logic [IDX_W:0]   LENGTH,
  output logic [31:0]      INCREMENT,
  output logic             GATE,
  output logic             BUSY,
  output logic             DONE,
  output logic [IDX_W-1:0] CUR_IDX
);
  localparam int PS_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
  state_t state, state_d;
  logic [31:0] incr_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem [DEPTH];
  logic [IDX_W:0] len, len_d;
  logic loop_l, loop_d;
  logic [PS_W-1:0] ps, ps_d;
  logic [DUR_W-1:0] dur_cnt, dur_d, rd_dur;
  logic [31:0] incr_d, rd_incr;
  logic [IDX_W-1:0] idx_d;
  logic gate_d, busy_d, done_d;
  logic start_ok, tick, last, adv, fin, load_go, halt;
  assign rd_incr  = incr_mem[CUR_IDX];
  assign rd_dur   = dur_mem[CUR_IDX];
  assign start_ok = START && !STOP && |LENGTH;
  assign tick     = ps == PS_MAX;
  assign last     = {1'b0, CUR_IDX} == len - (IDX_W + 1)'(1);
  assign adv      = state == LOAD ? rd_dur == '0 : state == PLAY && tick && dur_cnt == DUR_W'(1);
  assign fin      = adv && last && !loop_l;
  assign halt     = state != IDLE && STOP;
  assign load_go  = state == LOAD && !STOP && !adv;
  always_ff @(posedge CLOCK)
    if (WR_EN) begin
      incr_mem[WR_ADDR] <= WR_INCR;
      dur_mem[WR_ADDR]  <= WR_DUR;
    end
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) begin
      state     <= IDLE;
      len       <= '0;
      loop_l    <= 1'b0;
      ps        <= '0;
      dur_cnt   <= '0;
      INCREMENT <= '0;
      GATE      <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      CUR_IDX   <= '0;
    end else begin
      state     <= state_d;
      len       <= len_d;
      loop_l    <= loop_d;
      ps        <= ps_d;
      dur_cnt   <= dur_d;
      INCREMENT <= incr_d;
      GATE      <= gate_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
      CUR_IDX   <= idx_d;
    end
  always_comb
    state_d = state == IDLE ? (start_ok ? LOAD : IDLE) :
              halt || fin   ? IDLE :
              adv           ? LOAD : PLAY;
  always_comb begin
    len_d  = state == IDLE && start_ok ? (LENGTH > DEPTH_L ? DEPTH_L : LENGTH) : len;
    loop_d = state == IDLE && start_ok ? LOOP : loop_l;
    idx_d  = state == IDLE ? (start_ok ? '0 : CUR_IDX) :
             !STOP && adv && !fin ? (last ? '0 : CUR_IDX + IDX_W'(1)) : CUR_IDX;
    ps_d   = load_go ? '0 : state == PLAY ? (tick ? '0 : ps + PS_W'(1)) : ps;
    dur_d  = load_go ? rd_dur : state == PLAY && tick ? dur_cnt - DUR_W'(1) : dur_cnt;
    incr_d = halt || fin ? '0 : load_go ? rd_incr : INCREMENT;
    gate_d = halt || fin ? 1'b0 : load_go ? rd_incr != '0 : GATE;
    busy_d = state == IDLE ? start_ok : !(halt || fin);
    done_d = !halt && fin;
  end
endmodule

// File: tb/tb_dds_tone_sequencer.sv
// tb_dds_tone_sequencer: directed checks of the tone sequencer with TICK_DIV=4
module tb_dds_tone_sequencer;
  logic CLOCK = 1'b0, RESET = 1'b1, WR_EN = 1'b0, START = 1'b0, STOP = 1'b0, LOOP = 1'b0;
  logic [3:0] WR_ADDR = '0;
  logic [31:0] WR_INCR = '0;
  logic [15:0] WR_DUR = '0;
  logic [4:0] LENGTH = '0;
  logic [31:0] INCREMENT;
  logic GATE, BUSY, DONE;
  logic [3:0] CUR_IDX;
  int total = 0, bad = 0;
  dds_tone_sequencer #(.DEPTH(16), .IDX_W(4), .DUR_W(16), .TICK_DIV(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_INCR(WR_INCR),
    .WR_DUR(WR_DUR), .START(START), .STOP(STOP), .LOOP(LOOP), .LENGTH(LENGTH),
    .INCREMENT(INCREMENT), .GATE(GATE), .BUSY(BUSY), .DONE(DONE), .CUR_IDX(CUR_IDX)
  );
  always #5 CLOCK = ~CLOCK;
  task cyc;
    @(posedge CLOCK);
    @(negedge CLOCK);
  endtask
  task wr(input int a, input logic [31:0] inc, input int d);
    WR_EN = 1'b1;
    WR_ADDR = 4'(a);
    WR_INCR = inc;
    WR_DUR = 16'(d);
    cyc();
    WR_EN = 1'b0;
  endtask
  task go(input int len, input logic lp);
    LENGTH = 5'(len);
    LOOP = lp;
    START = 1'b1;
    cyc();
    START = 1'b0;
  endtask
  task test_reset;
    #2;
    total++;
    if ({INCREMENT, GATE, BUSY, DONE, CUR_IDX} !== 39'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {INCREMENT, GATE, BUSY, DONE, CUR_IDX});
    end
    @(negedge CLOCK);
    RESET = 1'b0;
    cyc();
    total++;
    if (BUSY !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy got=%b want=0", BUSY);
    end
  endtask
  task test_oneshot;
    logic [31:0] ei;
    logic eg, eb, ed;
    wr(0, 75591, 2);
    wr(1, 0, 1);
    wr(2, 171799, 3);
    go(3, 1'b0);
    total++;
    if ({BUSY, GATE, DONE} !== 3'b100 || INCREMENT !== 32'd0) begin
      bad++;
      $display("FAIL oneshot_start got busy=%b gate=%b done=%b inc=%0d want 1 0 0 0", BUSY, GATE, DONE, INCREMENT);
    end
    for (int c = 2; c <= 29; c++) begin
      cyc();
      ei = c <= 10 ? 75591 : c <= 15 ? 0 : c <= 27 ? 171799 : 0;
      eg = c <= 10 || (c >= 16 && c <= 27);
      eb = c <= 27;
      ed = c == 28;
      total++;
      if ({INCREMENT, GATE, BUSY, DONE} !== {ei, eg, eb, ed}) begin
        bad++;
        $display("FAIL oneshot c=%0d got inc=%0d g=%b b=%b d=%b want inc=%0d g=%b b=%b d=%b",
                 c, INCREMENT, GATE, BUSY, DONE, ei, eg, eb, ed);
      end
    end
  endtask
  task test_loop_stop;
    go(3, 1'b1);
    for (int c = 2; c <= 41; c++) begin
      cyc();
      total++;
      if (DONE !== 1'b0 || BUSY !== (c <= 40)) begin
        bad++;
        $display("FAIL loop_flags c=%0d got done=%b busy=%b want done=0 busy=%b", c, DONE, BUSY, c <= 40);
      end
      if (c == 28) begin
        total++;
        if (INCREMENT !== 32'd171799) begin
          bad++;
          $display("FAIL loop_load_hold got=%0d want=171799", INCREMENT);
        end
      end
      if (c == 29) begin
        total++;
        if (INCREMENT !== 32'd75591 || CUR_IDX !== 4'd0) begin
          bad++;
          $display("FAIL loop_wrap got inc=%0d idx=%0d want inc=75591 idx=0", INCREMENT, CUR_IDX);
        end
      end
      if (c == 40) begin
        total++;
        if (INCREMENT !== 32'd0 || CUR_IDX !== 4'd1) begin
          bad++;
          $display("FAIL loop_e1 got inc=%0d idx=%0d want inc=0 idx=1", INCREMENT, CUR_IDX);
        end
        STOP = 1'b1;
      end
      if (c == 41) begin
        STOP = 1'b0;
        total++;
        if ({INCREMENT, GATE, BUSY, DONE, CUR_IDX} !== {32'd0, 3'b000, 4'd1}) begin
          bad++;
          $display("FAIL stop got=%h want=%h", {INCREMENT, GATE, BUSY, DONE, CUR_IDX}, {32'd0, 3'b000, 4'd1});
        end
      end
    end
  endtask
  task test_async_reset;
    go(3, 1'b0);
    for (int c = 2; c <= 20; c++) cyc();
    #2 RESET = 1'b1;
    #1;
    total++;
    if ({INCREMENT, GATE, BUSY, DONE, CUR_IDX} !== 39'd0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0", {INCREMENT, GATE, BUSY, DONE, CUR_IDX});
    end
    @(negedge CLOCK);
    RESET = 1'b0;
    cyc();
    go(3, 1'b0);
    for (int c = 2; c <= 28; c++) begin
      cyc();
      if (c == 2) begin
        total++;
        if (INCREMENT !== 32'd75591 || GATE !== 1'b1 || CUR_IDX !== 4'd0) begin
          bad++;
          $display("FAIL replay_e0 got inc=%0d g=%b idx=%0d want 75591 1 0", INCREMENT, GATE, CUR_IDX);
        end
      end
      if (c == 16) begin
        total++;
        if (INCREMENT !== 32'd171799) begin
          bad++;
          $display("FAIL replay_e2 got=%0d want=171799", INCREMENT);
        end
      end
      if (c == 28) begin
        total++;
        if (DONE !== 1'b1 || BUSY !== 1'b0) begin
          bad++;
          $display("FAIL replay_done got done=%b busy=%b want 1 0", DONE, BUSY);
        end
      end
    end
  endtask
  task test_length_edges;
    int done_cnt, done_at;
    go(0, 1'b0);
    total++;
    if (BUSY !== 1'b0) begin
      bad++;
      $display("FAIL len0 busy got=%b want=0", BUSY);
    end
    LENGTH = 5'd3;
    START = 1'b1;
    STOP = 1'b1;
    cyc();
    START = 1'b0;
    STOP = 1'b0;
    cyc();
    total++;
    if (BUSY !== 1'b0) begin
      bad++;
      $display("FAIL start_stop_idle busy got=%b want=0", BUSY);
    end
    for (int i = 3; i < 16; i++) wr(i, 32'(i * 1000), 1);
    go(20, 1'b0);
    done_cnt = 0;
    done_at = 0;
    for (int c = 2; c <= 95; c++) begin
      cyc();
      if (DONE === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      START = c == 50;
      LENGTH = c == 50 ? 5'd2 : 5'd20;
      if (c == 52) begin
        total++;
        if (CUR_IDX !== 4'd7) begin
          bad++;
          $display("FAIL busy_start_idx got=%0d want=7", CUR_IDX);
        end
      end
      if (c == 89) begin
        total++;
        if (INCREMENT !== 32'd15000 || CUR_IDX !== 4'd15) begin
          bad++;
          $display("FAIL len20_e15 got inc=%0d idx=%0d want 15000 15", INCREMENT, CUR_IDX);
        end
      end
    end
    total++;
    if (done_cnt !== 1 || done_at !== 93 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL len20_done got cnt=%0d at=%0d busy=%b want 1 93 0", done_cnt, done_at, BUSY);
    end
  endtask
  task test_loop_write;
    wr(0, 75591, 2);
    go(3, 1'b1);
    for (int c = 2; c <= 83; c++) begin
      cyc();
      WR_EN = 1'b0;
      if (c == 29 || c == 56 || c == 83) begin
        total++;
        if (INCREMENT !== (c == 83 ? 32'd99999 : 32'd151182)) begin
          bad++;
          $display("FAIL loop_write c=%0d got=%0d want=%0d", c, INCREMENT, c == 83 ? 99999 : 151182);
        end
      end
      if (c == 12 || c == 55) begin
        WR_EN = 1'b1;
        WR_ADDR = 4'd0;
        WR_INCR = c == 12 ? 32'd151182 : 32'd99999;
        WR_DUR = 16'd2;
      end
    end
    STOP = 1'b1;
    cyc();
    STOP = 1'b0;
    total++;
    if (BUSY !== 1'b0) begin
      bad++;
      $display("FAIL loop_write_stop busy got=%b want=0", BUSY);
    end
  endtask
  task test_skip;
    int ones;
    logic [31:0] ei;
    wr(0, 75591, 2);
    wr(1, 55555, 0);
    wr(2, 171799, 1);
    go(3, 1'b0);
    ones = 0;
    for (int c = 2; c <= 17; c++) begin
      cyc();
      if (CUR_IDX === 4'd1) ones++;
      ei = c <= 11 ? 75591 : c <= 15 ? 171799 : 0;
      total++;
      if (INCREMENT !== ei || GATE !== (c <= 15) || DONE !== (c == 16)) begin
        bad++;
        $display("FAIL skip c=%0d got inc=%0d g=%b d=%b want inc=%0d g=%b d=%b",
                 c, INCREMENT, GATE, DONE, ei, c <= 15, c == 16);
      end
    end
    total++;
    if (ones !== 1) begin
      bad++;
      $display("FAIL skip_idx1_cycles got=%0d want=1", ones);
    end
  endtask
  initial begin
    test_reset();
    test_oneshot();
    test_loop_stop();
    test_async_reset();
    test_length_edges();
    test_loop_write();
    test_skip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
